ksa16_addsub_pipe: RTL

- Pipelined valid/ready front-end and back-end for the combinational 16-bit Kogge-Stone add/sub datapath.
- Registers one operand pair and drives the adder's A/B/Cin inputs.
- Captures the adder's Sum/Carry on the next edge, derives N/Z/C/V flags and queues results in a small output FIFO.
- Gives the 16-bit adder a one-op-per-cycle streaming interface to upstream producers and downstream consumers.

---
 rtl/ksa16_addsub_pipe_pkg.sv | 47 ++++
 rtl/ksa16_result_fifo.sv | 68 ++++++
 rtl/ksa16_addsub_pipe.sv | 107 ++++++++++
 3 files changed

// File: rtl/ksa16_addsub_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ksa16_addsub_pipe_pkg                                        |
// | Description : Shared constants, result record and flag helper for the      |
// |               16-bit add/sub pipeline wrapper.                             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ksa16_addsub_pipe_pkg;

    localparam int   c_data_w = 16;

    localparam int   c_flag_n = 3;
    localparam int   c_flag_z = 2;
    localparam int   c_flag_c = 1;
    localparam int   c_flag_v = 0;

    localparam logic c_op_add = 1'b0;
    localparam logic c_op_sub = 1'b1;

    typedef struct packed {
        logic [c_data_w-1:0] sum;
        logic [3:0]          flags;
    } result_t;

    // B is the raw operand, so subtraction overflow uses opposite-sign operands.
    function automatic logic [3:0] calc_flags(
        input logic [c_data_w-1:0] a,
        input logic [c_data_w-1:0] b,
        input logic                op,
        input logic [c_data_w-1:0] sum,
        input logic                carry
    );
        logic [3:0] f;
        f           = '0;
        f[c_flag_n] = sum[c_data_w-1];
        f[c_flag_z] = (sum == '0);
        f[c_flag_c] = carry;
        if (op == c_op_sub) begin
            f[c_flag_v] = (a[c_data_w-1] != b[c_data_w-1]) && (sum[c_data_w-1] != a[c_data_w-1]);
        end else begin
            f[c_flag_v] = (a[c_data_w-1] == b[c_data_w-1]) && (sum[c_data_w-1] != a[c_data_w-1]);
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ksa16_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ksa16_result_fifo                                            |
// | Description : DEPTH-entry in-order result FIFO with same-cycle push/pop;   |
// |               head reads zero while empty.                                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ksa16_result_fifo
    import ksa16_addsub_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  result_t i_push_data,
    input  logic    i_pop,
    output result_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    result_t            r_mem [DEPTH];

    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ksa16_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ksa16_addsub_pipe                                            |
// | Description : Valid/ready operand stage, flag derivation and result FIFO   |
// |               around an external combinational 16-bit add/sub datapath.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ksa16_addsub_pipe
    import ksa16_addsub_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_A,
    input  logic [15:0]      in_B,
    input  logic             in_op,
    output logic [15:0]      add_A,
    output logic [15:0]      add_B,
    output logic             add_Cin,
    input  logic [15:0]      add_Sum,
    input  logic             add_Carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_Sum,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ops_done
);

    logic                r_s1_valid;
    logic [c_data_w-1:0] r_s1_a;
    logic [c_data_w-1:0] r_s1_b;
    logic                r_s1_op;
    logic [CNT_W-1:0]    r_ops_done;

    logic                w_pop;
    logic                w_s1_adv;
    logic                w_accept;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    result_t             w_push_data;
    result_t             w_head;

    assign w_pop     = out_valid && out_ready;
    assign w_s1_adv  = r_s1_valid && (!w_fifo_full || w_pop);
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    assign add_A     = r_s1_a;
    assign add_B     = r_s1_b;
    assign add_Cin   = r_s1_op;

    // Operand registers only change on accept, so the adder inputs stay quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= c_op_add;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_A;
            r_s1_b     <= in_B;
            r_s1_op    <= in_op;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_comb begin
        w_push_data       = '0;
        w_push_data.sum   = add_Sum;
        w_push_data.flags = calc_flags(r_s1_a, r_s1_b, r_s1_op, add_Sum, add_Carry);
    end

    ksa16_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_s1_adv),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign out_Sum   = w_head.sum;
    assign out_flags = w_head.flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_done <= '0;
        end else if (w_pop) begin
            r_ops_done <= r_ops_done + CNT_W'(1);
        end
    end

    assign ops_done = r_ops_done;

endmodule
`default_nettype wire
